// File: rtl/regfile_pkg.sv
// Shared sizes and types for the writeback-side register file.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  typedef logic [NUM_REGS-1:0] reg_sel_t;
  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [DATA_W-1:0]   reg_data_t;

endpackage

// File: rtl/onehot_check.sv
// Classifies a select vector as one-hot and/or all-zero.
module onehot_check
  import regfile_pkg::*;
#(
  parameter int unsigned Width = NUM_REGS
) (
  input  logic [Width-1:0] vec,
  output logic             is_onehot,
  output logic             is_zero
);

  // A nonzero vector is one-hot when clearing its lowest set bit leaves nothing.
  always_comb begin
    is_zero   = (vec == '0);
    is_onehot = !is_zero && ((vec & (vec - Width'(1))) == '0);
  end

endmodule

// File: rtl/reg_file_wb.sv
// Writeback register file with two async read ports and a pending-write scoreboard.
// Optional write-through bypass: define REGFILE_BYPASS_EN.
module reg_file_wb
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  reg_sel_t  wr_sel,
  input  reg_data_t wr_data,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  output reg_data_t rd_data_a,
  output reg_data_t rd_data_b,
  input  logic      iss_en,
  input  reg_sel_t  iss_sel,
  output logic      stall,
  output reg_sel_t  busy_vec,
  output logic      sel_err
);

  reg_data_t regs_q [NUM_REGS];
  reg_data_t regs_d [NUM_REGS];
  reg_sel_t  busy_q, busy_d, busy_eff;
  logic      err_q, err_d;

  logic wr_onehot, wr_zero, iss_onehot, iss_zero;
  logic wr_legal, wr_illegal, iss_legal, iss_illegal;

  onehot_check #(.Width(NUM_REGS)) u_wr_chk (
    .vec       (wr_sel),
    .is_onehot (wr_onehot),
    .is_zero   (wr_zero)
  );

  onehot_check #(.Width(NUM_REGS)) u_iss_chk (
    .vec       (iss_sel),
    .is_onehot (iss_onehot),
    .is_zero   (iss_zero)
  );

  always_comb begin
    wr_legal    = wr_en & wr_onehot;
    wr_illegal  = wr_en & (wr_zero | ~wr_onehot);
    iss_legal   = iss_en & iss_onehot;
    iss_illegal = iss_en & (iss_zero | ~iss_onehot);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_legal) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) regs_d[i] = wr_data;
      end
    end
  end

  // Issue is applied after writeback so a same-register issue keeps the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_legal)  busy_d = busy_d & ~wr_sel;
    if (iss_legal) busy_d = busy_d | iss_sel;
    err_d = err_q | wr_illegal | iss_illegal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    busy_eff  = busy_q;
`ifdef REGFILE_BYPASS_EN
    if (wr_legal) begin
      if (wr_sel[rd_addr_a]) rd_data_a = wr_data;
      if (wr_sel[rd_addr_b]) rd_data_b = wr_data;
      busy_eff = busy_q & ~wr_sel;
    end
`endif
    stall = busy_eff[rd_addr_a] | busy_eff[rd_addr_b];
  end

  assign busy_vec = busy_q;
  assign sel_err  = err_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed, table-driven bench for reg_file_wb; expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_sel;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        iss_en;
  logic [31:0] iss_sel;
  logic        stall;
  logic [31:0] busy_vec;
  logic        sel_err;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  reg_file_wb dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .iss_en    (iss_en),
    .iss_sel   (iss_sel),
    .stall     (stall),
    .busy_vec  (busy_vec),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_sel;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [31:0] iss_sel;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_stall;
    logic [31:0] exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [31:0] ws, input logic [31:0] wd,
                     input logic ie, input logic [31:0] is, input logic [4:0] ra,
                     input logic [4:0] rb, input logic [31:0] ea, input logic [31:0] eb,
                     input logic es, input logic [31:0] ebusy, input logic ee);
    vec_t v;
    v.wr_en = we; v.wr_sel = ws; v.wr_data = wd; v.iss_en = ie; v.iss_sel = is;
    v.ra = ra; v.rb = rb; v.exp_a = ea; v.exp_b = eb; v.exp_stall = es;
    v.exp_busy = ebusy; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, exp);
  endtask

  task automatic drive_idle();
    wr_en = 1'b0; wr_sel = '0; wr_data = '0; iss_en = 1'b0; iss_sel = '0;
  endtask

  initial begin
    logic [31:0] b31, b0, b3;
    // Pre-edge expectations: outputs reflect state before this row's clock edge.
    b31 = Byp ? 32'hA5A5_0031 : 32'h0;
    b0  = Byp ? 32'h0000_C0DE : 32'h0;
    b3  = Byp ? 32'hDEAD_BEEF : 32'h0;
    //   we  wr_sel        wr_data       ie  iss_sel       ra  rb  exp_a          exp_b                 stl  busy          err
    add(0, 32'h0,         32'h0,         0, 32'h0,         0, 31, 32'h0,         32'h0,                0,   32'h0,        0);
    add(1, 32'h0000_0008, 32'hDEAD_BEEF, 0, 32'h0,         3,  0, b3,            32'h0,                0,   32'h0,        0);
    add(0, 32'h0,         32'h0,         0, 32'h0,         3,  4, 32'hDEAD_BEEF, 32'h0,                0,   32'h0,        0);
    add(0, 32'h0,         32'h0,         1, 32'h0000_0020, 3,  5, 32'hDEAD_BEEF, 32'h0,                0,   32'h0,        0);
    add(0, 32'h0,         32'h0,         0, 32'h0,         0,  5, 32'h0,         32'h0,                1,   32'h20,       0);
    add(1, 32'h0000_0020, 32'h55,        0, 32'h0,         3,  5, 32'hDEAD_BEEF, Byp ? 32'h55 : 32'h0, !Byp, 32'h20,      0);
    add(0, 32'h0,         32'h0,         0, 32'h0,         3,  5, 32'hDEAD_BEEF, 32'h55,               0,   32'h0,        0);
    add(1, 32'h0000_0100, 32'h88,        1, 32'h0000_0100, 8,  0, Byp ? 32'h88 : 32'h0, 32'h0,         0,   32'h0,        0);
    add(0, 32'h0,         32'h0,         0, 32'h0,         8,  0, 32'h88,        32'h0,                1,   32'h100,      0);
    add(1, 32'h0000_0003, 32'hFFFF_FFFF, 0, 32'h0,         0,  1, 32'h0,         32'h0,                0,   32'h100,      0);
    add(1, 32'h0,         32'h0000_1234, 0, 32'h0,         0,  1, 32'h0,         32'h0,                0,   32'h100,      1);
    add(0, 32'h0,         32'h0,         0, 32'h0,         0,  1, 32'h0,         32'h0,                0,   32'h100,      1);
    add(1, 32'h8000_0000, 32'hA5A5_0031, 0, 32'h0,        31, 31, b31,           b31,                  0,   32'h100,      1);
    add(1, 32'h0000_0001, 32'h0000_C0DE, 0, 32'h0,        31,  0, 32'hA5A5_0031, b0,                   0,   32'h100,      1);
    add(0, 32'h0,         32'h0,         0, 32'h0,        31, 31, 32'hA5A5_0031, 32'hA5A5_0031,        0,   32'h100,      1);
    add(0, 32'h0,         32'h0,         0, 32'h0,         0,  3, 32'h0000_C0DE, 32'hDEAD_BEEF,        0,   32'h100,      1);
    add(0, 32'h0000_0003, 32'h7777_7777, 0, 32'h0000_0003, 0,  8, 32'h0000_C0DE, 32'h88,               1,   32'h100,      1);
    add(0, 32'h0,         32'h0,         0, 32'h0,         0,  8, 32'h0000_C0DE, 32'h88,               1,   32'h100,      1);

    rst = 1'b1;
    drive_idle();
    rd_addr_a = '0;
    rd_addr_b = 5'd31;
    #2;
    check("reset.rd_a",  rd_data_a, 32'h0);
    check("reset.busy",  busy_vec,  32'h0);
    check("reset.err",   {31'h0, sel_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      wr_en = vecs[i].wr_en; wr_sel = vecs[i].wr_sel; wr_data = vecs[i].wr_data;
      iss_en = vecs[i].iss_en; iss_sel = vecs[i].iss_sel;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      @(negedge clk);
      check($sformatf("v%0d.rd_a", i),  rd_data_a,          vecs[i].exp_a);
      check($sformatf("v%0d.rd_b", i),  rd_data_b,          vecs[i].exp_b);
      check($sformatf("v%0d.stall", i), {31'h0, stall},     {31'h0, vecs[i].exp_stall});
      check($sformatf("v%0d.busy", i),  busy_vec,           vecs[i].exp_busy);
      check($sformatf("v%0d.err", i),   {31'h0, sel_err},   {31'h0, vecs[i].exp_err});
    end

    // Asynchronous reset mid-cycle with loaded state clears outputs immediately.
    @(posedge clk);
    #1;
    drive_idle();
    rd_addr_a = 5'd31;
    rd_addr_b = 5'd8;
    #2;
    check("midrst.pre_stall", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst.rd_a",  rd_data_a,        32'h0);
    check("midrst.rd_b",  rd_data_b,        32'h0);
    check("midrst.busy",  busy_vec,         32'h0);
    check("midrst.err",   {31'h0, sel_err}, 32'h0);
    check("midrst.stall", {31'h0, stall},   32'h0);

    // Write presented across a clock edge while reset is held is dropped.
    wr_en = 1'b1; wr_sel = 32'h0000_0004; wr_data = 32'hCAFE_F00D;
    iss_en = 1'b1; iss_sel = 32'h0000_0004;
    rd_addr_a = 5'd2;
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    check("rstwr.rd_a", rd_data_a, 32'h0);
    check("rstwr.busy", busy_vec,  32'h0);

    // Multi-hot issue select: no busy bits, sticky error.
    @(posedge clk);
    #1;
    iss_en = 1'b1; iss_sel = 32'h0000_0006;
    rd_addr_a = 5'd1; rd_addr_b = 5'd2;
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    check("issbad.busy",  busy_vec,         32'h0);
    check("issbad.err",   {31'h0, sel_err}, 32'h1);
    check("issbad.stall", {31'h0, stall},   32'h0);

    // Zero issue select after reset also flags the error.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    check("issz.err_cleared", {31'h0, sel_err}, 32'h0);
    @(posedge clk);
    #1;
    iss_en = 1'b1; iss_sel = 32'h0;
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    check("issz.err", {31'h0, sel_err}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
